// File: rtl/pc_pkg.sv
// Shared op encodings for the program-counter unit.
package pc_pkg;

  typedef logic [2:0] pc_op_t;

  localparam pc_op_t OP_INC      = 3'b000;
  localparam pc_op_t OP_REL      = 3'b001;
  localparam pc_op_t OP_ABS      = 3'b010;
  localparam pc_op_t OP_CALL_REL = 3'b011;
  localparam pc_op_t OP_CALL_ABS = 3'b100;
  localparam pc_op_t OP_RET      = 3'b101;
  localparam pc_op_t OP_HOLD     = 3'b110;

endpackage

// File: rtl/ras_stack.sv
// Return-address stack: circular buffer, top pointer and occupancy count.
// A push when full overwrites the oldest entry; a pop when empty changes nothing.
module ras_stack #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full,
  output logic             ovf_evt,
  output logic             unf_evt
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    top, top_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;

  assign dout    = mem[top];
  assign ovf_evt = push & full;
  assign unf_evt = pop & empty;

  always_comb begin
    top_nxt = top;
    cnt_nxt = cnt;
    if (push) begin
      // pointer wraps naturally since the depth is a power of two
      top_nxt = top + 1'b1;
      if (!full) cnt_nxt = cnt + 1'b1;
    end else if (pop && !empty) begin
      top_nxt = top - 1'b1;
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      top   <= '0;
      cnt   <= '0;
      empty <= 1'b1;
      full  <= 1'b0;
    end else begin
      top   <= top_nxt;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      full  <= (cnt_nxt == DEPTH_C);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[top_nxt] <= din;
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with sequential/relative/absolute update, call/return via
// a hardware return-address stack, and sticky stack fault flags.
module pc_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter int               STEP         = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int               RAS_DEPTH    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step_pc,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] systembus_in,
  input  logic             bus_oe,
  output logic [WIDTH-1:0] systembus_out,
  output logic [WIDTH-1:0] pc_out,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_ovf,
  output logic             ras_unf,
  input  logic             fault_clr
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] pc, pc_nxt, pc_seq, ras_dout;
  logic             push, pop, ovf_evt, unf_evt;
  pc_op_t           op_q;

  assign op_q          = pc_op_t'(op);
  assign pc_seq        = pc + STEP_W;
  assign pc_out        = pc;
  assign systembus_out = bus_oe ? pc : '0;

  always_comb begin
    pc_nxt = pc;
    push   = 1'b0;
    pop    = 1'b0;
    if (step_pc) begin
      unique case (op_q)
        OP_INC:      pc_nxt = pc_seq;
        OP_REL:      pc_nxt = pc + systembus_in;
        OP_ABS:      pc_nxt = systembus_in;
        OP_CALL_REL: begin push = 1'b1; pc_nxt = pc + systembus_in; end
        OP_CALL_ABS: begin push = 1'b1; pc_nxt = systembus_in; end
        // an empty-stack return falls through to the next instruction
        OP_RET:      begin pop = 1'b1; pc_nxt = ras_empty ? pc_seq : ras_dout; end
        default:     pc_nxt = pc;
      endcase
    end
  end

  ras_stack #(.WIDTH(WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk     (clk),
    .rst     (rst),
    .push    (push),
    .pop     (pop),
    .din     (pc_seq),
    .dout    (ras_dout),
    .empty   (ras_empty),
    .full    (ras_full),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // a fault arriving with fault_clr leaves the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= RESET_VECTOR;
      ras_ovf <= 1'b0;
      ras_unf <= 1'b0;
    end else begin
      pc      <= pc_nxt;
      ras_ovf <= (ras_ovf & ~fault_clr) | ovf_evt;
      ras_unf <= (ras_unf & ~fault_clr) | unf_evt;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed scenarios then random ops, checked
// against a queue-based behavioural model of the PC and return stack.
module tb_pc_unit;
  localparam int          W     = 32;
  localparam int          DEPTH = 8;
  localparam logic [31:0] RV    = 32'h100;

  logic          clk = 1'b0;
  logic          rst, step_pc, bus_oe, fault_clr;
  logic [2:0]    op;
  logic [W-1:0]  systembus_in, systembus_out, pc_out;
  logic          ras_empty, ras_full, ras_ovf, ras_unf;

  always #5 clk = ~clk;

  pc_unit #(.WIDTH(W), .STEP(4), .RESET_VECTOR(RV), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .step_pc(step_pc), .op(op),
    .systembus_in(systembus_in), .bus_oe(bus_oe),
    .systembus_out(systembus_out), .pc_out(pc_out),
    .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_ovf(ras_ovf), .ras_unf(ras_unf), .fault_clr(fault_clr)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] sysout;
    logic        empty, full, ovf, unf;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_stk[$];
  logic [31:0] m_pc;
  logic        m_ovf, m_unf;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-cycle semantics, stack as a queue (back = most recent).
  task automatic cyc(input bit r, input bit s, input logic [2:0] o,
                     input logic [31:0] b, input bit oe, input bit fc);
    exp_t e;
    bit   ovf_ev = 0, unf_ev = 0;
    @(negedge clk);
    rst = r; step_pc = s; op = o; systembus_in = b; bus_oe = oe; fault_clr = fc;
    if (r) begin
      m_pc = RV; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      if (s) begin
        case (o)
          3'd0: m_pc = m_pc + 4;
          3'd1: m_pc = m_pc + b;
          3'd2: m_pc = b;
          3'd3, 3'd4: begin
            if (m_stk.size() == DEPTH) begin void'(m_stk.pop_front()); ovf_ev = 1; end
            m_stk.push_back(m_pc + 4);
            m_pc = (o == 3'd3) ? m_pc + b : b;
          end
          3'd5: begin
            if (m_stk.size() == 0) begin m_pc = m_pc + 4; unf_ev = 1; end
            else m_pc = m_stk.pop_back();
          end
          default: ;
        endcase
      end
      m_ovf = (m_ovf && !fc) || ovf_ev;
      m_unf = (m_unf && !fc) || unf_ev;
    end
    e.pc = m_pc; e.sysout = oe ? m_pc : 32'h0;
    e.empty = (m_stk.size() == 0); e.full = (m_stk.size() == DEPTH);
    e.ovf = m_ovf; e.unf = m_unf;
    sbq.push_back(e);
  endtask

  // Monitor: every clock with an outstanding expectation, compare after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("systembus_out", systembus_out, e.sysout);
        chk("ras_empty", {31'h0, ras_empty}, {31'h0, e.empty});
        chk("ras_full", {31'h0, ras_full}, {31'h0, e.full});
        chk("ras_ovf", {31'h0, ras_ovf}, {31'h0, e.ovf});
        chk("ras_unf", {31'h0, ras_unf}, {31'h0, e.unf});
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1; step_pc = 0; op = 0; systembus_in = 0; bus_oe = 0; fault_clr = 0;
    m_pc = RV; m_ovf = 0; m_unf = 0;
    cyc(1, 0, 3'd0, 0, 0, 0);
    repeat (3) cyc(0, 1, 3'd0, 32'hdead_beef, 0, 0);
    repeat (2) cyc(0, 0, 3'd0, 0, 0, 0);
    cyc(0, 1, 3'd2, 32'hFFFF_FFFC, 0, 0);
    cyc(0, 1, 3'd0, 0, 0, 0);
    cyc(0, 1, 3'd2, 32'h40, 0, 0);
    cyc(0, 1, 3'd1, 32'hFFFF_FFF0, 0, 0);
    cyc(0, 1, 3'd2, 32'h100, 0, 0);
    cyc(0, 1, 3'd4, 32'h2000, 0, 0);
    cyc(0, 1, 3'd5, 0, 0, 0);
    cyc(0, 1, 3'd2, 32'h0, 0, 0);
    repeat (DEPTH + 1) cyc(0, 1, 3'd3, 32'h10, 0, 0);
    repeat (DEPTH + 1) cyc(0, 1, 3'd5, 0, 0, 0);
    cyc(0, 1, 3'd5, 0, 0, 1);
    cyc(0, 0, 3'd5, 0, 0, 1);
    cyc(0, 1, 3'd2, 32'h1234, 1, 0);
    cyc(0, 1, 3'd6, 0, 0, 0);
    cyc(0, 1, 3'd7, 0, 1, 0);
    cyc(0, 1, 3'd3, 32'h80, 0, 0);
    cyc(1, 1, 3'd3, 32'h80, 0, 0);
    cyc(0, 1, 3'd5, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [2:0] ro = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) ro = $urandom_range(0, 1) ? 3'd3 : 3'd5;
      cyc($urandom_range(0, 60) == 0, $urandom_range(0, 7) != 0, ro,
          $urandom, 1'($urandom), $urandom_range(0, 9) == 0);
    end
    @(posedge clk); #3;
    n_chk++;
    if (sbq.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
